// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types, constants and helpers for the 4x4 keypad scanner.
//   scan_state_t : scanner FSM states
//   COL_PAT      : column drive patterns, index = col_idx (active column low)
//   ROWS_IDLE    : row value seen when no key in the driven column is pressed
//   row_info_t   : decoded view of an active-low row vector
//   decode_rows  : returns the index of the low row and whether exactly one
//                  row is low
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } scan_state_t;

  localparam logic [3:0] COL_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [3:0] ROWS_IDLE   = 4'b1111;

  typedef struct packed {
    logic       one_hot;  // exactly one row is low
    logic [1:0] row_idx;  // index of the lowest low row, row 0 = bit 0
  } row_info_t;

  function automatic row_info_t decode_rows(input logic [3:0] rows_n);
    row_info_t   info;
    int unsigned lows;
    info = '0;
    lows = 0;
    // Walk from the top so the lowest low bit wins; only meaningful when
    // one_hot is set, since multi-key presses are rejected anyway.
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) begin
        lows++;
        info.row_idx = 2'(i);
      end
    end
    info.one_hot = (lows == 1);
    return info;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad matrix pins and the key-event outputs.
//   row_in    : matrix rows, active-low, asynchronous to clk
//   col_out   : column drive, active column low
//   key_code  : {row_idx, col_idx} of the last accepted key
//   key_valid : one-cycle pulse, key_code valid in the same cycle
//   key_held  : high while an accepted or rejected press is still held
// master : the scanner; slave : the matrix / downstream consumer side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if;

  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Column dwell divider. Counts 0..SCAN_DIV-1 and raises tick for the single
// cycle in which the count sits at SCAN_DIV-1, after which it wraps to 0.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle dwell-end strobe
// -----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int              CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low key matrix one column per dwell, debounces the row
// returns and emits one key_valid pulse per accepted single-key press.
// Multi-key presses are held off (key_held) without producing a pulse.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : keypad_scanner_if.master (row_in in; col_out, key_code,
//           key_valid, key_held out -- all outputs registered)
// Parameters:
//   SCAN_DIV       : clk cycles per column dwell (>= 4)
//   DEBOUNCE_TICKS : stable dwell ticks needed to accept a press or release
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_scanner_if.master   bus
);

  localparam int               DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_TICKS);

  logic             tick;
  logic [3:0]       row_meta;
  logic [3:0]       row_s;
  scan_state_t      state;
  scan_state_t      state_next;
  logic [3:0]       row_lat;
  logic [1:0]       col_idx;
  logic [1:0]       col_nxt;
  logic [1:0]       col_lat;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_inc;
  logic             rows_idle;
  logic             rows_match;
  row_info_t        lat_info;

  logic latch_rows;
  logic deb_clear;
  logic deb_step;
  logic col_step;
  logic accept;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer; cleared to "no key" so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= ROWS_IDLE;
      row_s    <= ROWS_IDLE;
    end else begin
      row_meta <= bus.row_in;
      row_s    <= row_meta;
    end
  end

  assign rows_idle  = (row_s == ROWS_IDLE);
  assign rows_match = (row_s == row_lat);
  assign col_nxt    = col_idx + 2'd1;
  assign lat_info   = decode_rows(row_lat);
  // Saturating step; the FSM leaves the counting state on DEB_DONE anyway.
  assign deb_inc    = (deb_cnt == DEB_DONE) ? deb_cnt : deb_cnt + 1'b1;

  // --- FSM: state register --------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SCAN;
    end else begin
      state <= state_next;
    end
  end

  // --- FSM: next state (decisions only on dwell ticks) ----------------------
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // state_next unassigned, which would infer a latch.
    state_next = state;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (!rows_idle) state_next = ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (!rows_match)               state_next = ST_SCAN;
          else if (deb_inc == DEB_DONE)  state_next = ST_HELD;
        end
        ST_HELD: begin
          if (rows_idle) state_next = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!rows_idle)                state_next = ST_HELD;
          else if (deb_inc == DEB_DONE)  state_next = ST_SCAN;
        end
        default: state_next = ST_SCAN;
      endcase
    end
  end

  // --- FSM: per-state actions -----------------------------------------------
  always_comb begin
    latch_rows = 1'b0;
    deb_clear  = 1'b0;
    deb_step   = 1'b0;
    col_step   = 1'b0;
    accept     = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (rows_idle) col_step   = 1'b1;
          else           latch_rows = 1'b1;
        end
        ST_DEBOUNCE: begin
          if (rows_match) begin
            deb_step = 1'b1;
            // A multi-key press still reaches HELD, just without a pulse.
            accept   = (deb_inc == DEB_DONE) && lat_info.one_hot;
          end else begin
            // Bounce: abandon this column rather than re-sampling it.
            col_step = 1'b1;
          end
        end
        ST_HELD: begin
          deb_clear = rows_idle;
        end
        ST_RELEASE: begin
          if (rows_idle) begin
            deb_step = 1'b1;
            col_step = (deb_inc == DEB_DONE);
          end
        end
        default: ;
      endcase
    end
  end

  // --- Datapath: latched press, debounce counter, column index --------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_lat <= ROWS_IDLE;
      col_lat <= '0;
      deb_cnt <= '0;
      col_idx <= '0;
    end else begin
      if (latch_rows) begin
        row_lat <= row_s;
        col_lat <= col_idx;
      end
      if (latch_rows || deb_clear) begin
        deb_cnt <= '0;
      end else if (deb_step) begin
        deb_cnt <= deb_inc;
      end
      if (col_step) begin
        col_idx <= col_nxt;
      end
    end
  end

  // --- Registered outputs ---------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.col_out   <= COL_PAT[0];
      bus.key_code  <= '0;
      bus.key_valid <= 1'b0;
      bus.key_held  <= 1'b0;
    end else begin
      bus.key_valid <= accept;
      // Built from state_next so key_held rises with key_valid and falls right
      // after the release-completing tick.
      bus.key_held  <= (state_next == ST_HELD) || (state_next == ST_RELEASE);
      if (col_step) begin
        bus.col_out <= COL_PAT[col_nxt];
      end
      if (accept) begin
        bus.key_code <= {lat_info.row_idx, col_lat};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Drives keypad_scanner (SCAN_DIV=4, DEBOUNCE_TICKS=3) through a small model
// of the key matrix: a row reads low when a pressed key sits in a row whose
// column is currently driven low. Expected key codes go into a queue when a
// press is made; a negedge monitor pops and compares them on every key_valid.
// cyc counts rising edges since the last reset release, so after rising edge
// k the divider holds k mod 4 and dwell ticks fall in cycles with cyc mod 4 = 3.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_TICKS = 3;
  localparam int LATENCY   = DEB_TICKS * SCAN_DIV + 1;
  localparam logic [3:0] PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [3:0] CODE_R1C2 = 4'b0110;
  localparam int         KEY_R1C2  = 1 * 4 + 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  row_model;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_count = 0;
  int last_pulse_cyc = -1;
  logic [3:0] exp_q [$];

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEB_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !bus.col_out[c]) row_model[r] = 1'b0;
      end
    end
  end
  assign bus.row_in = row_model;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard monitor: every pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n && bus.key_valid === 1'b1) begin
      pulse_count++;
      last_pulse_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: key_valid high at cyc %0d with code %b, no pulse expected", cyc, bus.key_code);
      end else begin
        logic [3:0] exp_code;
        exp_code = exp_q.pop_front();
        if (bus.key_code !== exp_code) begin
          errors++;
          $display("FAIL pulse_code: got %b expected %b at cyc %0d", bus.key_code, exp_code, cyc);
        end
      end
      checks++;
      if (bus.key_held !== 1'b1) begin
        errors++;
        $display("FAIL pulse_held: key_held got %b expected 1 with key_valid", bus.key_held);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != target) begin
      errors++;
      $display("FAIL wait_cyc: reached cyc %0d expected %0d", cyc, target);
    end
  endtask

  task automatic wait_col(input logic [3:0] pat, input string name);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.col_out !== pat && guard < 64);
    checks++;
    if (bus.col_out !== pat) begin
      errors++;
      $display("FAIL %s: col_out got %b expected %b (timeout)", name, bus.col_out, pat);
    end
  endtask

  task automatic wait_pulse(input string name, input int budget);
    int start = pulse_count;
    int guard = 0;
    while (pulse_count == start && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (pulse_count == start) begin
      errors++;
      $display("FAIL %s: no key_valid within %0d cycles, got 0 pulses expected 1", name, budget);
    end
  endtask

  task automatic wait_held(input logic level, input string name, input int budget);
    int guard = 0;
    while (bus.key_held !== level && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.key_held !== level) begin
      errors++;
      $display("FAIL %s: key_held got %b expected %b within %0d cycles", name, bus.key_held, level, budget);
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.col_out !== 4'b1110) begin errors++; $display("FAIL reset_col_out: got %b expected 1110", bus.col_out); end
    checks++;
    if (bus.key_code !== 4'b0000) begin errors++; $display("FAIL reset_key_code: got %b expected 0000", bus.key_code); end
    checks++;
    if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", bus.key_valid); end
    checks++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", bus.key_held); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (bus.col_out !== PAT[(cyc / SCAN_DIV) % 4]) begin
        errors++;
        $display("FAIL idle_col_out: got %b expected %b at cyc %0d", bus.col_out, PAT[(cyc / SCAN_DIV) % 4], cyc);
      end
      @(negedge clk);
    end
    checks++;
    if (pulse_count != 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulse_count); end
  endtask

  task automatic test_press;
    // cyc = 40: column 2 has just become active; its dwell tick is cyc 43.
    checks++;
    if (bus.col_out !== 4'b1011) begin errors++; $display("FAIL press_start_col: got %b expected 1011", bus.col_out); end
    pressed[KEY_R1C2] = 1'b1;
    exp_q.push_back(CODE_R1C2);
    wait_pulse("press_pulse", 60);
    checks++;
    if (last_pulse_cyc != 43 + LATENCY) begin
      errors++;
      $display("FAIL press_latency: pulse at cyc %0d expected %0d", last_pulse_cyc, 43 + LATENCY);
    end
    wait_cyc(last_pulse_cyc + 1);
    checks++;
    if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL press_pulse_width: key_valid got %b expected 0", bus.key_valid); end
    checks++;
    if (bus.key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", bus.key_held); end
    checks++;
    if (bus.col_out !== 4'b1011) begin errors++; $display("FAIL press_frozen: col_out got %b expected 1011", bus.col_out); end
  endtask

  task automatic test_hold_release;
    int rel_cyc = last_pulse_cyc + 100;
    int guard = 0;
    while (cyc < rel_cyc && guard < 200) begin
      checks++;
      if (bus.col_out !== 4'b1011 || bus.key_held !== 1'b1) begin
        errors++;
        $display("FAIL hold_frozen: col_out %b key_held %b expected 1011 1 at cyc %0d", bus.col_out, bus.key_held, cyc);
      end
      @(negedge clk);
      guard++;
    end
    // Released in a divider-0 cycle: first clean tick at +4 enters RELEASE,
    // three more clean ticks at +8, +12, +16 finish it.
    pressed[KEY_R1C2] = 1'b0;
    wait_cyc(rel_cyc + 15);
    checks++;
    if (bus.key_held !== 1'b1) begin errors++; $display("FAIL release_early: key_held got %b expected 1", bus.key_held); end
    wait_cyc(rel_cyc + 16);
    checks++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL release_fall: key_held got %b expected 0", bus.key_held); end
    checks++;
    if (bus.col_out !== 4'b0111) begin errors++; $display("FAIL release_next_col: col_out got %b expected 0111", bus.col_out); end
    checks++;
    if (pulse_count != 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulse_count); end
  endtask

  task automatic test_bounce;
    int c0;
    wait_col(4'b1011, "bounce_col");
    c0 = cyc;
    pressed[KEY_R1C2] = 1'b1;
    wait_cyc(c0 + SCAN_DIV);
    pressed[KEY_R1C2] = 1'b0;
    wait_cyc(c0 + 2 * SCAN_DIV);
    checks++;
    if (bus.col_out !== 4'b0111) begin errors++; $display("FAIL bounce_abort_col: col_out got %b expected 0111", bus.col_out); end
    checks++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b expected 0", bus.key_held); end
    checks++;
    if (pulse_count != 1) begin errors++; $display("FAIL bounce_no_pulse: got %0d pulses expected 1", pulse_count); end
    pressed[KEY_R1C2] = 1'b1;
    exp_q.push_back(CODE_R1C2);
    wait_pulse("bounce_stable_pulse", 100);
    repeat (8) @(negedge clk);
    checks++;
    if (pulse_count != 2) begin errors++; $display("FAIL bounce_pulses: got %0d expected 2", pulse_count); end
    pressed[KEY_R1C2] = 1'b0;
    wait_held(1'b0, "bounce_release", 80);
  endtask

  task automatic test_multi_key;
    pressed[0] = 1'b1;  // row 0, col 0
    pressed[4] = 1'b1;  // row 1, col 0
    wait_held(1'b1, "multi_held", 80);
    repeat (20) @(negedge clk);
    checks++;
    if (bus.key_held !== 1'b1) begin errors++; $display("FAIL multi_still_held: got %b expected 1", bus.key_held); end
    checks++;
    if (bus.key_code !== CODE_R1C2) begin errors++; $display("FAIL multi_code: got %b expected %b", bus.key_code, CODE_R1C2); end
    checks++;
    if (pulse_count != 2) begin errors++; $display("FAIL multi_no_pulse: got %0d pulses expected 2", pulse_count); end
    pressed = '0;
    wait_held(1'b0, "multi_release", 80);
    checks++;
    if (bus.key_code !== CODE_R1C2) begin errors++; $display("FAIL multi_code_after: got %b expected %b", bus.key_code, CODE_R1C2); end
  endtask

  task automatic test_reset_mid_press;
    int c0;
    wait_col(4'b1011, "rst_col");
    c0 = cyc;
    pressed[KEY_R1C2] = 1'b1;
    wait_cyc(c0 + SCAN_DIV + 2);  // DEBOUNCE entered at the tick ending cycle c0+3
    checks++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL rst_pre_held: got %b expected 0", bus.key_held); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.col_out !== 4'b1110) begin errors++; $display("FAIL rst_mid_col_out: got %b expected 1110", bus.col_out); end
    checks++;
    if (bus.key_code !== 4'b0000) begin errors++; $display("FAIL rst_mid_key_code: got %b expected 0000", bus.key_code); end
    checks++;
    if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_key_valid: got %b expected 0", bus.key_valid); end
    checks++;
    if (bus.key_held !== 1'b0) begin errors++; $display("FAIL rst_mid_key_held: got %b expected 0", bus.key_held); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(CODE_R1C2);
    wait_pulse("rst_fresh_pulse", 60);
    // Column 2 is the third dwell after reset, so its tick is cycle 11.
    checks++;
    if (last_pulse_cyc != 3 * SCAN_DIV - 1 + LATENCY) begin
      errors++;
      $display("FAIL rst_latency: pulse at cyc %0d expected %0d", last_pulse_cyc, 3 * SCAN_DIV - 1 + LATENCY);
    end
    pressed = '0;
    wait_held(1'b0, "rst_release", 80);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press();
    test_hold_release();
    test_bounce();
    test_multi_key();
    test_reset_mid_press();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d pulses outstanding, expected 0", exp_q.size()); end
    checks++;
    if (pulse_count != 3) begin errors++; $display("FAIL total_pulses: got %0d expected 3", pulse_count); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the multiplexed 7-segment display driver. It scans a 4x4 active-low key matrix one column at a time and debounces the row returns. For each accepted press it reports a single key code as a one-cycle pulse, which feeds the fan-speed and mode control logic.

## Interface
- SCAN_DIV, default 1000: clk cycles per column dwell; legal range is 4 or more.
- DEBOUNCE_TICKS, default 8: consecutive stable dwell ticks required to accept a press or a release; legal range is 1 or more.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- row_in  input  4  matrix rows; active-low and externally pulled up; asynchronous to clk.
- col_out  output  4  column drive; the active column is low.
- key_code  output  4  code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-cycle pulse; key_code is valid in the same cycle.
- key_held  output  1  high while an accepted key or a rejected multi-key press is still held.

## Operation
- row_in passes through a 2-flop synchronizer to produce row_s.
- Dwell tick:
  - The divider counts 0 to SCAN_DIV-1.
  - tick is high for one cycle at SCAN_DIV-1, then the divider wraps to 0.
- Column pattern sequence is 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - col_idx is 0-3; col_idx 0 corresponds to 1110.
- FSM states are SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - On tick with row_s == 1111: advance the column.
  - On tick with row_s != 1111: latch row_s into row_lat and col_idx into col_lat, clear deb_cnt, go to DEBOUNCE. The column does not advance.
- DEBOUNCE (column frozen):
  - On tick with row_s == row_lat: increment deb_cnt.
  - On tick with row_s != row_lat: go to SCAN and advance the column. No output is produced.
  - When deb_cnt reaches DEBOUNCE_TICKS with exactly one bit of row_lat low:
    - key_code <= {row_idx, col_lat}; row_idx is the index of the low bit, with row_in[0] as index 0.
    - Pulse key_valid.
    - Go to HELD.
  - When deb_cnt reaches DEBOUNCE_TICKS with two or more bits low: go to HELD with no pulse and key_code unchanged (multi-key reject).
- HELD:
  - key_held = 1 and the column stays frozen.
  - On tick with row_s == 1111: clear deb_cnt and go to RELEASE.
- RELEASE:
  - key_held = 1.
  - On tick with row_s == 1111: increment deb_cnt.
  - On tick with any row low: go back to HELD.
  - When deb_cnt reaches DEBOUNCE_TICKS: go to SCAN and advance the column.
- A held key produces exactly one key_valid. There is no auto-repeat.
- Reset values:
  - col_out = 1110, key_code = 0000, key_valid = 0, key_held = 0.
  - FSM in SCAN; divider, deb_cnt and synchronizer cleared, with the synchronizer cleared to 1111.
- Reset asserted mid-press: all state returns to reset values immediately. After release of reset, a still-held key is debounced afresh and produces one new pulse.

## Timing
- Every FSM decision is made only on tick cycles. Rows are sampled at the end of the dwell, at least 4 clocks after the column change, so the synchronizer has settled.
- key_valid is high in the cycle after the tick on which deb_cnt reaches DEBOUNCE_TICKS, for exactly 1 cycle.
- Press-to-pulse latency after the first low sample: DEBOUNCE_TICKS*SCAN_DIV + 1 clocks.
- col_out, key_code, key_valid and key_held are all registered outputs.
- key_held rises together with key_valid. It falls in the cycle after the release-completing tick.
- deb_cnt is $clog2(DEBOUNCE_TICKS+1) bits wide and saturates; it never wraps.

## Structure
- Package keypad_pkg:
  - The state enum.
  - COL_PAT[4] column patterns.
  - A function returning the row index and a one-hot check for a 4-bit active-low vector.
- Sub-module scan_tick_gen (parameter SCAN_DIV): divider plus single-cycle tick output.
- Everything else lives in one module: synchronizer, FSM, column register and output registers.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_TICKS=3.
- Idle rows 1111 for 40 clocks -> col_out cycles 1110, 1101, 1011, 0111, with each pattern lasting 4 clocks; key_valid is never asserted.
- While col_out=1011, drive row_in=1101 steadily -> one key_valid pulse with key_code=0110 (row 1, col 2); key_held=1; col_out frozen at 1011.
- Bounce: row_in=1101 for 1 tick, then 1111, then 1101 -> the first contact aborts to SCAN with no pulse; a later stable press produces exactly one pulse.
- Hold the key for 100 clocks, then release for 3 or more ticks -> only 1 pulse; key_held falls after 3 clean ticks; scanning resumes at the next column (0111).
- Two rows low (row_in=1100) on col 0 -> no key_valid and key_code unchanged; key_held=1 until release.
- Assert rst_n low mid-DEBOUNCE -> outputs at reset values within the same cycle. After release of reset with the key still held -> one fresh pulse, with latency 3*4+1 clocks from the first low sample.
